// File: rtl/snap_vacc_capture_ctrl.sv
// Snapshot capture controller: writes a burst of accumulator words into the
// snapshot BRAM and publishes a done/busy/word-count status word for software.
module snap_vacc_capture_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              ctrl_arm,
  input  logic              ctrl_trig_sel,
  input  logic              sync_in,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status_addr
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int PAD_W = 30 - CNT_W;
  localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                arm_d_reg;
  logic                arm_ok_reg;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [31:0]         status_reg, status_next;
  logic                arm_rise;
  logic                wr_en;
  logic                busy;
  logic                done;

  // arm_ok_reg masks the first cycle after reset so a level held through
  // reset release is not mistaken for a rising edge.
  assign arm_rise = ctrl_arm & ~arm_d_reg & arm_ok_reg;

  always_comb begin
    wr_en       = 1'b0;
    state_next  = state_reg;
    count_next  = count_reg;
    we_next     = 1'b0;
    addr_next   = addr_reg;
    data_next   = data_reg;
    busy        = (state_reg == ST_WAIT_TRIG) || (state_reg == ST_CAPTURE);
    done        = (state_reg == ST_DONE);
    status_next = {done, busy, {PAD_W{1'b0}}, count_reg};

    if (arm_rise) begin
      // Re-arm wins over any word presented in the same cycle.
      count_next = '0;
      state_next = ctrl_trig_sel ? ST_WAIT_TRIG : ST_CAPTURE;
    end else begin
      case (state_reg)
        ST_WAIT_TRIG: begin
          if (sync_in) begin
            state_next = ST_CAPTURE;
            wr_en      = din_valid;
          end
        end
        ST_CAPTURE: wr_en = din_valid;
        default: ;
      endcase

      if (wr_en) begin
        we_next    = 1'b1;
        addr_next  = count_reg[ADDR_W-1:0];
        data_next  = din;
        count_next = count_reg + CNT_W'(1);
        if (count_reg == LAST_IDX) begin
          state_next = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      arm_d_reg  <= 1'b0;
      arm_ok_reg <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
      status_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      arm_d_reg  <= ctrl_arm;
      arm_ok_reg <= 1'b1;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      // Flags and count land in one register so a re-sampling reader never
      // sees them disagree.
      status_reg <= status_next;
    end
  end

  assign bram_we     = we_reg;
  assign bram_addr   = addr_reg;
  assign bram_data   = data_reg;
  assign status_addr = status_reg;

endmodule

// File: tb/tb_snap_vacc_capture_ctrl.sv
// Bench for snap_vacc_capture_ctrl (depth 16): directed scenarios plus a random
// soak, every cycle compared against a phase/word-count reference model.
module tb_snap_vacc_capture_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_CAP  = 2;
  localparam int P_FULL = 3;

  logic          user_clk = 1'b0;
  logic          user_rst_n = 1'b0;
  logic          ctrl_arm = 1'b0;
  logic          ctrl_trig_sel = 1'b0;
  logic          sync_in = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          bram_we;
  logic [31:0]   status_addr;

  int checks_total = 0;
  int checks_pass  = 0;
  int n_writes     = 0;

  int m_phase    = P_IDLE;
  int m_n        = 0;
  bit m_prev_arm = 1'b1;

  snap_vacc_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .user_clk      (user_clk),
    .user_rst_n    (user_rst_n),
    .ctrl_arm      (ctrl_arm),
    .ctrl_trig_sel (ctrl_trig_sel),
    .sync_in       (sync_in),
    .din           (din),
    .din_valid     (din_valid),
    .bram_addr     (bram_addr),
    .bram_data     (bram_data),
    .bram_we       (bram_we),
    .status_addr   (status_addr)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] flags;
    if (m_phase == P_FULL) flags = 32'h8000_0000;
    else if (m_phase == P_IDLE) flags = 32'h0;
    else flags = 32'h4000_0000;
    return flags | 32'(m_n);
  endfunction

  // One clock: drive inputs, advance the model, then compare the outputs.
  task automatic step(input bit rst_n, input bit arm, input bit sel, input bit sync,
                      input bit dv, input logic [31:0] d);
    logic [31:0] exp_status;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    bit          rise;
    @(negedge user_clk);
    user_rst_n    = rst_n;
    ctrl_arm      = arm;
    ctrl_trig_sel = sel;
    sync_in       = sync;
    din_valid     = dv;
    din           = d;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    if (!rst_n) begin
      exp_status = '0;
      m_phase    = P_IDLE;
      m_n        = 0;
      m_prev_arm = 1'b1;
    end else begin
      exp_status = model_status();
      rise       = arm && !m_prev_arm;
      m_prev_arm = arm;
      if (rise) begin
        m_n     = 0;
        m_phase = sel ? P_WAIT : P_CAP;
      end else if (dv && (m_phase == P_CAP || (m_phase == P_WAIT && sync))) begin
        exp_we   = 1'b1;
        exp_addr = 32'(m_n);
        exp_data = d;
        m_n++;
        m_phase  = (m_n == DEPTH) ? P_FULL : P_CAP;
      end else if (m_phase == P_WAIT && sync) begin
        m_phase = P_CAP;
      end
    end
    @(posedge user_clk);
    #1;
    chk("bram_we", {31'b0, bram_we}, {31'b0, exp_we});
    if (exp_we || !rst_n) begin
      chk("bram_addr", {28'b0, bram_addr}, exp_addr);
      chk("bram_data", bram_data, exp_data);
    end
    chk("status_addr", status_addr, exp_status);
    if (bram_we === 1'b1) n_writes++;
  endtask

  initial begin
    bit s_arm;
    int nv;

    // Arm held high through reset release must not arm.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    n_writes = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, $urandom);
    chk("noarm_writes", 32'(n_writes), 32'd0);
    chk("noarm_status", status_addr, 32'h0);

    // Immediate capture, 20 valids into a 16-deep buffer.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_writes = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100 + 32'(i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("imm_writes", 32'(n_writes), 32'd16);
    chk("imm_final_status", status_addr, 32'h8000_0010);

    // Triggered capture: valids before sync are dropped.
    n_writes = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, $urandom);
    chk("trig_wait_writes", 32'(n_writes), 32'd0);
    chk("trig_wait_status", status_addr, 32'h4000_0000);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAA);
    chk("trig_we", {31'b0, bram_we}, 32'd1);
    chk("trig_addr", {28'b0, bram_addr}, 32'd0);
    chk("trig_data", bram_data, 32'hAA);

    // Gapped valid: one word every third cycle.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_writes = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, $urandom_range(0, 1) == 1, (i % 3) == 2, $urandom);
    chk("gap_writes", 32'(n_writes), 32'd16);
    chk("gap_status", status_addr, 32'h8000_0010);

    // Re-arm after 7 words, coincident with a valid word.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("rearm_no_write", {31'b0, bram_we}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5A5A_0001);
    chk("rearm_addr0", {28'b0, bram_addr}, 32'd0);
    chk("rearm_count0", status_addr, 32'h4000_0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);

    // Reset after 5 words, then a fresh arm starts at address 0.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);
    chk("rst_status", status_addr, 32'h0);
    chk("rst_we", {31'b0, bram_we}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);
    chk("rst_idle_we", {31'b0, bram_we}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_7777);
    chk("rst_rearm_addr0", {28'b0, bram_addr}, 32'd0);
    chk("rst_rearm_data", bram_data, 32'h0000_7777);

    // Random soak across all inputs, including occasional resets.
    s_arm = 1'b0;
    nv    = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) s_arm = ~s_arm;
      step($urandom_range(0, 249) != 0, s_arm, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, $urandom);
      if (bram_we === 1'b1) nv++;
    end
    chk("soak_some_writes", 32'(nv > 0), 32'd1);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
